// File: rtl/types_pkg.sv
// Shared types for the rename/dispatch boundary: instruction bundles, FU encodings
// and physical-register sizing.
package types_pkg;

  localparam int NUM_PREGS = 128;
  localparam int PREG_W    = $clog2(NUM_PREGS);
  localparam int ROB_TAG_W = 4;

  typedef logic [1:0] fu_t;

  localparam fu_t FU_ALU     = 2'd0;
  localparam fu_t FU_BR      = 2'd1;
  localparam fu_t FU_MEM     = 2'd2;
  localparam fu_t FU_ILLEGAL = 2'd3;

  typedef struct packed {
    logic [PREG_W-1:0]    ps1;
    logic [PREG_W-1:0]    ps2;
    logic [PREG_W-1:0]    pd_new;
    logic [PREG_W-1:0]    pd_old;
    logic [31:0]          imm;
    logic [ROB_TAG_W-1:0] rob_tag;
    fu_t                  fu;
    logic [3:0]           ALUOp;
    logic [6:0]           Opcode;
    logic [2:0]           func3;
    logic [6:0]           func7;
  } rename_data;

  typedef struct packed {
    logic [PREG_W-1:0]    ps1;
    logic [PREG_W-1:0]    ps2;
    logic [PREG_W-1:0]    pd_new;
    logic [PREG_W-1:0]    pd_old;
    logic [31:0]          imm;
    logic [ROB_TAG_W-1:0] rob_tag;
    fu_t                  fu;
    logic [3:0]           ALUOp;
    logic [6:0]           Opcode;
    logic [2:0]           func3;
    logic [6:0]           func7;
    logic                 ps1_ready;
    logic                 ps2_ready;
  } dispatch_data;

  // Widens a renamed instruction into the dispatch bundle with its source readiness.
  function automatic dispatch_data to_dispatch(input rename_data r,
                                               input logic r1,
                                               input logic r2);
    dispatch_data d;
    d.ps1       = r.ps1;
    d.ps2       = r.ps2;
    d.pd_new    = r.pd_new;
    d.pd_old    = r.pd_old;
    d.imm       = r.imm;
    d.rob_tag   = r.rob_tag;
    d.fu        = r.fu;
    d.ALUOp     = r.ALUOp;
    d.Opcode    = r.Opcode;
    d.func3     = r.func3;
    d.func7     = r.func7;
    d.ps1_ready = r1;
    d.ps2_ready = r2;
    return d;
  endfunction

endpackage

// File: rtl/preg_ready_table.sv
// Physical-register ready bits: set by CDB broadcasts, cleared on allocation,
// read through a same-cycle CDB bypass. Preg 0 is hard-wired ready.
module preg_ready_table #(
  parameter int NUM_PREGS = 128,
  parameter int PREG_W    = $clog2(NUM_PREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [PREG_W-1:0] set_idx,
  input  logic              clr_en,
  input  logic [PREG_W-1:0] clr_idx,
  input  logic [PREG_W-1:0] rd_idx_a,
  input  logic [PREG_W-1:0] rd_idx_b,
  output logic              rd_ready_a,
  output logic              rd_ready_b
);

  logic [NUM_PREGS-1:0] rdy;

  // The clear is written after the set so a same-index collision leaves the bit low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy <= '1;
    end else begin
      if (set_en) begin
        rdy[set_idx] <= 1'b1;
      end
      if (clr_en && (clr_idx != '0)) begin
        rdy[clr_idx] <= 1'b0;
      end
    end
  end

  assign rd_ready_a = rdy[rd_idx_a] || (set_en && (set_idx == rd_idx_a)) || (rd_idx_a == '0);
  assign rd_ready_b = rdy[rd_idx_b] || (set_en && (set_idx == rd_idx_b)) || (rd_idx_b == '0);

endmodule

// File: rtl/dispatch.sv
// Dispatch stage: one-entry output register fed by rename, issuing each held
// instruction to the ROB and its functional unit's reservation station together.
module dispatch
  import types_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  rename_data        data_in,
  output logic              ready_in,
  input  logic              mispredict,
  input  logic              cdb_valid,
  input  logic [PREG_W-1:0] cdb_pd,
  output dispatch_data      data_out,
  output logic              rob_valid,
  input  logic              rob_ready,
  output logic              rs_alu_valid,
  output logic              rs_br_valid,
  output logic              rs_mem_valid,
  input  logic              rs_alu_ready,
  input  logic              rs_br_ready,
  input  logic              rs_mem_ready
);

  // Handshake: a transfer to the ROB and the selected RS happens on a clock edge
  // where rob_valid && rob_ready && rs_X_valid && rs_X_ready all hold; valids never
  // depend on readies, and both sides always transfer together.

  logic         out_valid;
  dispatch_data data_q;
  logic         fu_ready;
  logic         issue;
  logic         drain;
  logic         accept;
  logic         ps1_rdy;
  logic         ps2_rdy;

  // An illegal fu has no RS to wait for, so it drains on ROB readiness alone.
  always_comb begin
    fu_ready = 1'b1;
    case (data_q.fu)
      FU_ALU:  fu_ready = rs_alu_ready;
      FU_BR:   fu_ready = rs_br_ready;
      FU_MEM:  fu_ready = rs_mem_ready;
      default: fu_ready = 1'b1;
    endcase
  end

  assign issue    = out_valid && !mispredict;
  assign drain    = issue && rob_ready && fu_ready;
  assign ready_in = !mispredict && (!out_valid || drain);
  assign accept   = valid_in && ready_in;

  preg_ready_table #(
    .NUM_PREGS (NUM_PREGS),
    .PREG_W    (PREG_W)
  ) u_ready_table (
    .clk        (clk),
    .reset      (reset),
    .set_en     (cdb_valid),
    .set_idx    (cdb_pd),
    .clr_en     (accept && (data_in.pd_new != '0)),
    .clr_idx    (data_in.pd_new),
    .rd_idx_a   (data_in.ps1),
    .rd_idx_b   (data_in.ps2),
    .rd_ready_a (ps1_rdy),
    .rd_ready_b (ps2_rdy)
  );

  // Mispredict drops the valid but leaves the payload untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      data_q    <= '0;
    end else if (mispredict) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      data_q    <= to_dispatch(data_in, ps1_rdy, ps2_rdy);
    end else if (drain) begin
      out_valid <= 1'b0;
    end else if (out_valid && cdb_valid) begin
      if (cdb_pd == data_q.ps1) begin
        data_q.ps1_ready <= 1'b1;
      end
      if (cdb_pd == data_q.ps2) begin
        data_q.ps2_ready <= 1'b1;
      end
    end
  end

  assign data_out     = data_q;
  assign rob_valid    = issue;
  assign rs_alu_valid = issue && (data_q.fu == FU_ALU);
  assign rs_br_valid  = issue && (data_q.fu == FU_BR);
  assign rs_mem_valid = issue && (data_q.fu == FU_MEM);

  fu_legal_a : assert property (@(posedge clk) disable iff (reset)
    out_valid |-> (data_q.fu != FU_ILLEGAL))
    else $error("dispatch: held instruction has illegal fu");

endmodule

// File: tb/tb_dispatch.sv
// Directed bench for dispatch: hand-computed readiness, stall, wakeup, bypass,
// mispredict and reset cases, with a drain scoreboard keyed on {fu, rob_tag}.
module tb_dispatch;
  import types_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_in;
  rename_data        data_in;
  logic              ready_in;
  logic              mispredict;
  logic              cdb_valid;
  logic [PREG_W-1:0] cdb_pd;
  dispatch_data      data_out;
  logic              rob_valid;
  logic              rob_ready;
  logic              rs_alu_valid;
  logic              rs_br_valid;
  logic              rs_mem_valid;
  logic              rs_alu_ready;
  logic              rs_br_ready;
  logic              rs_mem_ready;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_drains = 0;
  logic [5:0]  exp_q[$];
  dispatch_data exp_d;

  dispatch dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .ready_in     (ready_in),
    .mispredict   (mispredict),
    .cdb_valid    (cdb_valid),
    .cdb_pd       (cdb_pd),
    .data_out     (data_out),
    .rob_valid    (rob_valid),
    .rob_ready    (rob_ready),
    .rs_alu_valid (rs_alu_valid),
    .rs_br_valid  (rs_br_valid),
    .rs_mem_valid (rs_mem_valid),
    .rs_alu_ready (rs_alu_ready),
    .rs_br_ready  (rs_br_ready),
    .rs_mem_ready (rs_mem_ready)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change #1 after the rising edge, outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic rename_data mk(input logic [6:0] p1, input logic [6:0] p2,
                                    input logic [6:0] pd, input logic [3:0] tag,
                                    input logic [1:0] fu);
    rename_data r;
    r.ps1     = p1;
    r.ps2     = p2;
    r.pd_new  = pd;
    r.pd_old  = pd - 7'd1;
    r.imm     = {24'h0, 4'h1, tag};
    r.rob_tag = tag;
    r.fu      = fu;
    r.ALUOp   = 4'h2;
    r.Opcode  = 7'h33;
    r.func3   = 3'd0;
    r.func7   = 7'd0;
    return r;
  endfunction

  task automatic send(input rename_data r);
    valid_in = 1'b1;
    data_in  = r;
    exp_q.push_back({r.fu, r.rob_tag});
  endtask

  // Scoreboard: a drain is due at the next edge when the ROB and the selected RS are both ready.
  logic sel_ready;
  always_comb begin
    sel_ready = 1'b1;
    case (data_out.fu)
      FU_ALU:  sel_ready = rs_alu_ready;
      FU_BR:   sel_ready = rs_br_ready;
      FU_MEM:  sel_ready = rs_mem_ready;
      default: sel_ready = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    if (!reset && rob_valid && rob_ready && sel_ready) begin
      n_drains++;
      check("drain_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        check("drain_tag", {data_out.fu, data_out.rob_tag}, exp_q.pop_front());
      end
      check("drain_rs_strobe", rs_alu_valid | rs_br_valid | rs_mem_valid, 1'b1);
    end
  end

  initial begin
    reset        = 1'b1;
    valid_in     = 1'b0;
    data_in      = '0;
    mispredict   = 1'b0;
    cdb_valid    = 1'b0;
    cdb_pd       = '0;
    rob_ready    = 1'b1;
    rs_alu_ready = 1'b1;
    rs_br_ready  = 1'b1;
    rs_mem_ready = 1'b1;

    mid();
    check("rst_rob_valid", rob_valid, 1'b0);
    check("rst_rs_valids", {rs_alu_valid, rs_br_valid, rs_mem_valid}, 3'b000);
    check("rst_data_out", data_out, '0);
    check("rst_ready_in", ready_in, 1'b1);
    check("rst_rdy_all", dut.u_ready_table.rdy, {NUM_PREGS{1'b1}});
    step();
    reset = 1'b0;

    // A: add ps1=5 ps2=6 -> pd 40
    send(mk(7'd5, 7'd6, 7'd40, 4'd1, FU_ALU));
    mid();
    check("a_ready_in", ready_in, 1'b1);
    step();
    // B follows back-to-back, sourcing A's destination
    send(mk(7'd40, 7'd7, 7'd41, 4'd2, FU_ALU));
    mid();
    check("a_rob_valid", rob_valid, 1'b1);
    check("a_rs_alu_valid", rs_alu_valid, 1'b1);
    check("a_rs_br_valid", rs_br_valid, 1'b0);
    check("a_ps1_ready", data_out.ps1_ready, 1'b1);
    check("a_ps2_ready", data_out.ps2_ready, 1'b1);
    check("a_rob_tag", data_out.rob_tag, 4'd1);
    check("a_rdy40", dut.u_ready_table.rdy[40], 1'b0);
    check("a_ready_in_thru", ready_in, 1'b1);
    step();
    valid_in     = 1'b0;
    rs_alu_ready = 1'b0;
    mid();
    check("b_rob_tag", data_out.rob_tag, 4'd2);
    check("b_ps1_ready", data_out.ps1_ready, 1'b0);
    check("b_ps2_ready", data_out.ps2_ready, 1'b1);
    check("b_ready_in_stall", ready_in, 1'b0);
    step();
    cdb_valid = 1'b1;
    cdb_pd    = 7'd40;
    mid();
    check("b_ps1_pre_wake", data_out.ps1_ready, 1'b0);
    step();
    cdb_valid = 1'b0;
    mid();
    check("b_ps1_woken", data_out.ps1_ready, 1'b1);
    check("b_ps2_kept", data_out.ps2_ready, 1'b1);
    check("b_rdy40_set", dut.u_ready_table.rdy[40], 1'b1);
    check("b_held_valid", rob_valid, 1'b1);
    step();
    rs_alu_ready = 1'b1;
    mid();
    check("b_ready_in_drain", ready_in, 1'b1);
    step();

    // C: CDB bypass on ps2=41 in the accept cycle; ps1 is preg 0
    send(mk(7'd0, 7'd41, 7'd42, 4'd3, FU_BR));
    cdb_valid = 1'b1;
    cdb_pd    = 7'd41;
    mid();
    check("c_rdy41_before", dut.u_ready_table.rdy[41], 1'b0);
    check("c_idle_rob_valid", rob_valid, 1'b0);
    step();
    valid_in  = 1'b0;
    cdb_valid = 1'b0;
    mid();
    check("c_ps1_preg0", data_out.ps1_ready, 1'b1);
    check("c_ps2_bypass", data_out.ps2_ready, 1'b1);
    check("c_rs_br_valid", rs_br_valid, 1'b1);
    check("c_rs_alu_valid", rs_alu_valid, 1'b0);
    check("c_rdy42", dut.u_ready_table.rdy[42], 1'b0);
    step();

    // D: MEM instruction held by rs_mem_ready=0 for 5 cycles while E waits upstream
    send(mk(7'd42, 7'd3, 7'd43, 4'd4, FU_MEM));
    step();
    valid_in     = 1'b1;
    data_in      = mk(7'd9, 7'd10, 7'd44, 4'd5, FU_ALU);
    rs_mem_ready = 1'b0;
    exp_d = '0;
    exp_d.ps1       = 7'd42;
    exp_d.ps2       = 7'd3;
    exp_d.pd_new    = 7'd43;
    exp_d.pd_old    = 7'd42;
    exp_d.imm       = 32'h14;
    exp_d.rob_tag   = 4'd4;
    exp_d.fu        = FU_MEM;
    exp_d.ALUOp     = 4'h2;
    exp_d.Opcode    = 7'h33;
    exp_d.ps1_ready = 1'b0;
    exp_d.ps2_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mid();
      check("d_stable", data_out, exp_d);
      check("d_ready_in", ready_in, 1'b0);
      check("d_rs_mem_valid", rs_mem_valid, 1'b1);
      step();
    end
    check("d_e_not_taken", dut.u_ready_table.rdy[44], 1'b1);
    rs_mem_ready = 1'b1;
    valid_in     = 1'b0;
    mid();
    check("d_ready_in_release", ready_in, 1'b1);
    step();

    // F: BR instruction squashed by a mispredict while held; G offered during the flush
    send(mk(7'd1, 7'd2, 7'd45, 4'd6, FU_BR));
    rs_br_ready = 1'b0;
    step();
    data_in     = mk(7'd11, 7'd12, 7'd46, 4'd7, FU_ALU);
    valid_in    = 1'b1;
    mispredict  = 1'b1;
    rs_br_ready = 1'b1;
    mid();
    check("f_ready_in_flush", ready_in, 1'b0);
    check("f_rob_valid_masked", rob_valid, 1'b0);
    check("f_rs_br_masked", rs_br_valid, 1'b0);
    void'(exp_q.pop_back());
    step();
    mispredict = 1'b0;
    valid_in   = 1'b0;
    mid();
    check("f_out_valid_clr", rob_valid, 1'b0);
    check("f_data_kept", data_out.rob_tag, 4'd6);
    check("f_rdy45_kept", dut.u_ready_table.rdy[45], 1'b0);
    check("f_g_not_taken", dut.u_ready_table.rdy[46], 1'b1);
    step();

    // H: allocate pd 77 while the CDB broadcasts 77
    send(mk(7'd3, 7'd4, 7'd77, 4'd8, FU_ALU));
    cdb_valid = 1'b1;
    cdb_pd    = 7'd77;
    step();
    valid_in  = 1'b0;
    cdb_valid = 1'b0;
    mid();
    check("h_rdy77_clear_wins", dut.u_ready_table.rdy[77], 1'b0);
    check("h_rs_alu_valid", rs_alu_valid, 1'b1);
    step();

    // I: held under stall, then reset asserted between edges
    send(mk(7'd5, 7'd6, 7'd78, 4'd9, FU_ALU));
    rs_alu_ready = 1'b0;
    step();
    valid_in = 1'b0;
    mid();
    check("i_held", rob_valid, 1'b1);
    check("i_rdy78", dut.u_ready_table.rdy[78], 1'b0);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("async_rob_valid", rob_valid, 1'b0);
    check("async_rs_alu_valid", rs_alu_valid, 1'b0);
    check("async_data_out", data_out, '0);
    check("async_rdy_all", dut.u_ready_table.rdy, {NUM_PREGS{1'b1}});
    step();
    reset        = 1'b0;
    rs_alu_ready = 1'b1;
    mid();
    check("post_rst_rob_valid", rob_valid, 1'b0);
    check("post_rst_ready_in", ready_in, 1'b1);

    check("drain_count", n_drains, 5);
    check("exp_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dispatch.md
# dispatch

Dispatch stage sitting directly downstream of rename. It accepts one renamed instruction per cycle and looks up source-operand readiness in a physical-register ready table. Each instruction is held in a one-entry output register and issued simultaneously to the ROB and to the reservation station selected by its functional unit. The stage tracks CDB wakeups and flushes its held instruction on a mispredict.

## Interface
Parameters:
- NUM_PREGS, 128, physical registers; PREG_W = $clog2(NUM_PREGS) = 7
- ROB_TAG_W, 4, width of rob_tag carried in rename_data

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high; all state cleared on assertion
- valid_in  in  1  rename has an instruction on data_in
- data_in  in  rename_data  renamed instruction (ps1, ps2, pd_new, pd_old, imm, rob_tag, fu, ALUOp, Opcode, func3, func7)
- ready_in  out  1  dispatch accepts data_in this cycle
- mispredict  in  1  flush from ROB
- cdb_valid  in  1  a result is broadcast this cycle
- cdb_pd  in  PREG_W  physical register written by the broadcast
- data_out  out  dispatch_data  rename_data fields plus ps1_ready, ps2_ready
- rob_valid  out  1  allocate ROB entry
- rob_ready  in  1  ROB has a free entry
- rs_alu_valid / rs_br_valid / rs_mem_valid  out  1 each  target reservation station strobe
- rs_alu_ready / rs_br_ready / rs_mem_ready  in  1 each  reservation station has space

## Operation
- Output register:
  - out_valid plus data_out.
  - rob_valid = out_valid.
  - rs_X_valid = out_valid && (data_out.fu == FU_X).
  - Valids never depend on readies.
- Drain: drain = out_valid && rob_ready && rs_ready[data_out.fu]. ROB and RS transfer happen in the same cycle, never one without the other.
- Accept:
  - ready_in = !mispredict && (!out_valid || drain).
  - accept = valid_in && ready_in.
  - On accept, the register loads data_in with readiness fields set.
- Readiness on load:
  - ps1_ready = rdy[ps1] || (cdb_valid && cdb_pd == ps1); same rule for ps2.
  - Preg 0 always reads ready.
- Held-entry wakeup: while out_valid && !drain, a cdb_valid matching ps1/ps2 sets the corresponding ready bit in data_out.
- Ready table rdy[NUM_PREGS]:
  - Reset: all 1.
  - cdb_valid sets rdy[cdb_pd].
  - accept with pd_new != 0 clears rdy[pd_new].
  - Same index in the same cycle: clear wins.
  - rdy[0] is never cleared.
- fu with no matching RS (value 3): illegal. The assertion fires and the instruction drains on ROB ready alone.
- Mispredict:
  - out_valid <= 0 and data_out is unchanged.
  - No accept that cycle.
  - Ready table is not modified; squashed pregs are re-cleared when reallocated.
  - A drain coincident with mispredict is cancelled: valids are masked by !mispredict.

## Timing
- Latency 1 cycle: accepted at edge N, presented on outputs after edge N.
- Throughput 1/cycle when downstream is ready every cycle (load and drain in the same cycle).
- ready_in is combinational from rob_ready, rs_*_ready and mispredict; no combinational path from valid_in to ready_in.
- Reset values:
  - out_valid, rob_valid, rs_*_valid = 0.
  - data_out = '0.
  - rdy = all 1.
  - ready_in = 1 whenever mispredict = 0.
- Reset asserted mid-operation discards the held instruction immediately (asynchronous).
- Stall: data_out stays stable while valid is high and not drained, except for readiness bits set by wakeup.

## Structure
- types_pkg gains:
  - dispatch_data typedef (rename_data fields + ps1_ready, ps2_ready).
  - fu encoding constants FU_ALU = 2'd0, FU_BR = 2'd1, FU_MEM = 2'd2.
  - PREG_W.
- Sub-module preg_ready_table:
  - Ports: clk, reset, set_en/set_idx, clr_en/clr_idx, two read indices with CDB bypass, two ready outputs.
  - Instantiated once.
- Top level holds the output register, drain/accept logic and RS demux.

## Test plan
- After reset, send add with ps1 = 5, ps2 = 6, pd_new = 40, fu = FU_ALU, all readies high: next cycle rs_alu_valid = rob_valid = 1, ps1_ready = ps2_ready = 1, and rdy[40] = 0.
- Back-to-back: second instruction with ps1 = 40 → ps1_ready = 0. Then cdb_valid, cdb_pd = 40 while it is held with rs_alu_ready = 0 → ps1_ready flips to 1 in place, and it drains once ready rises.
- CDB bypass: cdb_pd = 40 in the same cycle as accepting an instruction with ps2 = 40 → ps2_ready = 1 on output.
- Backpressure: rs_mem_ready = 0, rob_ready = 1 with a FU_MEM instruction held → no drain, ready_in = 0, data_out stable for 5 cycles, ROB sees no allocation.
- Mispredict while holding a FU_BR instruction → out_valid = 0 next cycle, ready_in = 0 during the mispredict cycle, and no rs_br or ROB handshake occurs.
- Set/clear collision: accept pd_new = 77 while cdb_pd = 77 → rdy[77] = 0. Reset asserted mid-stall → all valids 0 asynchronously and rdy all 1.
